// File: rtl/alu_pkg.sv
// Shared definitions for the type-1/type-2 ALU feeders: opcodes, action-word
// field layout, feeder state encoding and the operand-source decode.
package alu_pkg;

  localparam int OPC_W    = 4;
  localparam int IDX_W    = 3;
  localparam int IMM_W    = 15;
  localparam int OPC_LSB  = 21;
  localparam int SRC1_LSB = 18;
  localparam int SRC2_LSB = 15;
  localparam int IMM_LSB  = 0;

  localparam logic [OPC_W-1:0] OP_ADD   = 4'b0001;
  localparam logic [OPC_W-1:0] OP_SUB   = 4'b0010;
  localparam logic [OPC_W-1:0] OP_ADDI  = 4'b1001;
  localparam logic [OPC_W-1:0] OP_SUBI  = 4'b1010;
  localparam logic [OPC_W-1:0] OP_STORE = 4'b1000;
  localparam logic [OPC_W-1:0] OP_LOAD  = 4'b1011;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_OUT   = 2'd3
  } feeder_state_t;

  typedef enum logic [1:0] {
    OPS_REG_REG  = 2'd0,
    OPS_REG_IMM  = 2'd1,
    OPS_IMM_ONLY = 2'd2,
    OPS_PASS     = 2'd3
  } opsel_t;

  function automatic opsel_t decode_opsel(input logic [OPC_W-1:0] opc);
    opsel_t sel;
    case (opc)
      OP_ADD, OP_SUB:              sel = OPS_REG_REG;
      OP_ADDI, OP_SUBI, OP_STORE:  sel = OPS_REG_IMM;
      OP_LOAD:                     sel = OPS_IMM_ONLY;
      default:                     sel = OPS_PASS;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/alu2_operand_feeder_if.sv
// PHV/action input, ALU issue/result and PHV output bundle of the type-2 ALU feeder.
interface alu2_operand_feeder_if #(
  parameter int ACTION_LEN = 25,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_CONT   = 8
);
  logic [NUM_CONT*DATA_WIDTH-1:0] phv_in;
  logic [ACTION_LEN-1:0]          action_in;
  logic                           in_valid;
  logic                           in_ready;
  logic [ACTION_LEN-1:0]          alu_action;
  logic                           alu_action_valid;
  logic [DATA_WIDTH-1:0]          alu_operand_1;
  logic [DATA_WIDTH-1:0]          alu_operand_2;
  logic [DATA_WIDTH-1:0]          alu_operand_3;
  logic [DATA_WIDTH-1:0]          alu_result;
  logic                           alu_result_valid;
  logic [NUM_CONT*DATA_WIDTH-1:0] phv_out;
  logic                           phv_out_valid;
  logic                           phv_out_ready;
  logic                           timeout_err;

  modport master (
    output phv_in, action_in, in_valid, alu_result, alu_result_valid, phv_out_ready,
    input  in_ready, alu_action, alu_action_valid, alu_operand_1, alu_operand_2,
           alu_operand_3, phv_out, phv_out_valid, timeout_err
  );

  modport slave (
    input  phv_in, action_in, in_valid, alu_result, alu_result_valid, phv_out_ready,
    output in_ready, alu_action, alu_action_valid, alu_operand_1, alu_operand_2,
           alu_operand_3, phv_out, phv_out_valid, timeout_err
  );
endinterface

// File: rtl/alu2_operand_mux.sv
// Container select plus opcode decode: derives the three ALU operands from a PHV
// and an action word. Purely combinational so either ALU feeder can reuse it.
module alu2_operand_mux
  import alu_pkg::*;
#(
  parameter int ACTION_LEN = 25,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_CONT   = 8,
  parameter int DST_IDX    = 0
) (
  input  logic [NUM_CONT*DATA_WIDTH-1:0] phv_i,
  input  logic [ACTION_LEN-1:0]          action_i,
  output logic [DATA_WIDTH-1:0]          op1_o,
  output logic [DATA_WIDTH-1:0]          op2_o,
  output logic [DATA_WIDTH-1:0]          op3_o
);

  logic [DATA_WIDTH-1:0] cont [NUM_CONT];
  logic [OPC_W-1:0]      opc;
  logic [IDX_W-1:0]      src1;
  logic [IDX_W-1:0]      src2;
  logic [IMM_W-1:0]      imm;
  logic [DATA_WIDTH-1:0] imm_ext;

  for (genvar i = 0; i < NUM_CONT; i++) begin : g_cont
    assign cont[i] = phv_i[i*DATA_WIDTH +: DATA_WIDTH];
  end

  assign opc     = action_i[OPC_LSB  +: OPC_W];
  assign src1    = action_i[SRC1_LSB +: IDX_W];
  assign src2    = action_i[SRC2_LSB +: IDX_W];
  assign imm     = action_i[IMM_LSB  +: IMM_W];
  assign imm_ext = DATA_WIDTH'(imm);

  always_comb begin
    op1_o = '0;
    op2_o = '0;
    op3_o = cont[DST_IDX];
    case (decode_opsel(opc))
      OPS_REG_REG: begin
        op1_o = cont[src1];
        op2_o = cont[src2];
      end
      OPS_REG_IMM: begin
        op1_o = cont[src1];
        op2_o = imm_ext;
      end
      OPS_IMM_ONLY: op2_o = imm_ext;
      default: ;
    endcase
  end

endmodule

// File: rtl/alu2_operand_feeder.sv
// Type-2 ALU operand feeder: latches a PHV/action pair, holds operands across the
// ALU's load/store window, merges the result into DST_IDX and hands the PHV on.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   S_IDLE  | in_ready high; accept PHV + action, load operand holds
//   S_ISSUE | single-cycle alu_action_valid, clear wait counter
//   S_WAIT  | await alu_result_valid or counter terminal count
//   S_OUT   | phv_out_valid high until phv_out_ready
module alu2_operand_feeder
  import alu_pkg::*;
#(
  parameter int STAGE_ID   = 0,
  parameter int ACTION_LEN = 25,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_CONT   = 8,
  parameter int DST_IDX    = 0,
  parameter int TIMEOUT    = 8
) (
  input logic            clk,
  input logic            rst,
  alu2_operand_feeder_if.slave bus
);

  localparam int PHV_W = NUM_CONT*DATA_WIDTH;
  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(TIMEOUT-1);

  if (TIMEOUT < 4 || STAGE_ID < 0) begin : g_param_check
    $error("alu2_operand_feeder: TIMEOUT must be >= 4 and STAGE_ID non-negative");
  end

  feeder_state_t         state_q, state_d;
  logic [PHV_W-1:0]      phv_q, phv_d;
  logic [ACTION_LEN-1:0] act_q, act_d;
  logic [DATA_WIDTH-1:0] op1_q, op1_d;
  logic [DATA_WIDTH-1:0] op2_q, op2_d;
  logic [DATA_WIDTH-1:0] op3_q, op3_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  err_q, err_d;
  logic [DATA_WIDTH-1:0] mux_op1, mux_op2, mux_op3;

  alu2_operand_mux #(
    .ACTION_LEN (ACTION_LEN),
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_CONT   (NUM_CONT),
    .DST_IDX    (DST_IDX)
  ) u_mux (
    .phv_i    (bus.phv_in),
    .action_i (bus.action_in),
    .op1_o    (mux_op1),
    .op2_o    (mux_op2),
    .op3_o    (mux_op3)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      phv_q   <= '0;
      act_q   <= '0;
      op1_q   <= '0;
      op2_q   <= '0;
      op3_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      phv_q   <= phv_d;
      act_q   <= act_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
      op3_q   <= op3_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Operand holds only reload on an IDLE accept; the ALU's RAM address depends on them.
  always_comb begin
    state_d = state_q;
    phv_d   = phv_q;
    act_d   = act_q;
    op1_d   = op1_q;
    op2_d   = op2_q;
    op3_d   = op3_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          phv_d   = bus.phv_in;
          act_d   = bus.action_in;
          op1_d   = mux_op1;
          op2_d   = mux_op2;
          op3_d   = mux_op3;
          err_d   = 1'b0;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (bus.alu_result_valid) begin
          phv_d[DST_IDX*DATA_WIDTH +: DATA_WIDTH] = bus.alu_result;
          err_d   = 1'b0;
          state_d = S_OUT;
        end else if (cnt_q == CNT_TC) begin
          err_d   = 1'b1;
          state_d = S_OUT;
        end
      end
      S_OUT: begin
        if (bus.phv_out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.in_ready         = (state_q == S_IDLE) && !rst;
  assign bus.alu_action       = act_q;
  assign bus.alu_action_valid = (state_q == S_ISSUE);
  assign bus.alu_operand_1    = op1_q;
  assign bus.alu_operand_2    = op2_q;
  assign bus.alu_operand_3    = op3_q;
  assign bus.phv_out          = phv_q;
  assign bus.phv_out_valid    = (state_q == S_OUT);
  assign bus.timeout_err      = err_q;

endmodule

// File: tb/tb_alu2_operand_feeder.sv
// Directed bench for alu2_operand_feeder: ADD, STORE with operand hold and
// backpressure, ADDI, LOAD timeout, timeout/result coincidence, reset mid-WAIT.
module tb_alu2_operand_feeder;
  import alu_pkg::*;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  alu2_operand_feeder_if bus ();

  alu2_operand_feeder #(
    .STAGE_ID(0), .ACTION_LEN(25), .DATA_WIDTH(32), .NUM_CONT(8), .DST_IDX(0), .TIMEOUT(8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_ops(input string tag, input logic [31:0] e1, input logic [31:0] e2,
                         input logic [31:0] e3);
    chk({tag, " op1"}, 256'(bus.alu_operand_1), 256'(e1));
    chk({tag, " op2"}, 256'(bus.alu_operand_2), 256'(e2));
    chk({tag, " op3"}, 256'(bus.alu_operand_3), 256'(e3));
  endtask

  logic [255:0] phv_a;
  logic [255:0] exp_phv;
  logic [24:0]  act;
  logic [24:0]  act2;
  logic         seen_valid;

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    bus.phv_in = '0;
    bus.action_in = '0;
    bus.in_valid = 1'b0;
    bus.alu_result = '0;
    bus.alu_result_valid = 1'b0;
    bus.phv_out_ready = 1'b1;

    phv_a = '0;
    phv_a[0*32 +: 32] = 32'h0000_0100;
    phv_a[1*32 +: 32] = 32'd5;
    phv_a[2*32 +: 32] = 32'd7;
    phv_a[3*32 +: 32] = 32'h0000_DEAD;
    phv_a[4*32 +: 32] = 32'h1234_5678;
    phv_a[5*32 +: 32] = 32'h0BAD_F00D;
    phv_a[6*32 +: 32] = 32'hCAFE_0006;
    phv_a[7*32 +: 32] = 32'h7777_0007;

    // ---- reset state
    repeat (2) @(negedge clk);
    chk("rst in_ready", 256'(bus.in_ready), 256'(0));
    chk("rst out_valid", 256'(bus.phv_out_valid), 256'(0));
    chk("rst action_valid", 256'(bus.alu_action_valid), 256'(0));
    chk("rst phv_out", bus.phv_out, 256'(0));
    chk_ops("rst", 32'h0, 32'h0, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    chk("post-rst in_ready", 256'(bus.in_ready), 256'(1));

    // ---- ADD: result three cycles after issue
    act = {OP_ADD, 3'd1, 3'd2, 15'd0};
    bus.phv_in = phv_a;
    bus.action_in = act;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("add action_valid", 256'(bus.alu_action_valid), 256'(1));
    chk("add alu_action", 256'(bus.alu_action), 256'(act));
    chk("add in_ready busy", 256'(bus.in_ready), 256'(0));
    chk_ops("add", 32'd5, 32'd7, 32'h100);
    @(negedge clk);
    chk("add pulse width", 256'(bus.alu_action_valid), 256'(0));
    @(negedge clk);
    @(negedge clk);
    chk("add valid early", 256'(bus.phv_out_valid), 256'(0));
    bus.alu_result = 32'd12;
    bus.alu_result_valid = 1'b1;
    @(negedge clk);
    bus.alu_result_valid = 1'b0;
    exp_phv = phv_a;
    exp_phv[31:0] = 32'd12;
    chk("add out_valid", 256'(bus.phv_out_valid), 256'(1));
    chk("add phv_out", bus.phv_out, exp_phv);
    chk("add timeout_err", 256'(bus.timeout_err), 256'(0));
    @(negedge clk);
    chk("add back to idle", 256'(bus.in_ready), 256'(1));
    chk("add valid drop", 256'(bus.phv_out_valid), 256'(0));

    // ---- STORE with operand hold, then 5 cycles of backpressure
    act = {OP_STORE, 3'd3, 3'd0, 15'h11};
    act2 = {OP_ADDI, 3'd2, 3'd0, 15'h7FFF};
    bus.action_in = act;
    bus.in_valid = 1'b1;
    bus.phv_out_ready = 1'b0;
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("st action_valid", 256'(bus.alu_action_valid), 256'(1));
    chk_ops("st issue", 32'hDEAD, 32'h11, 32'h100);
    @(negedge clk);
    chk_ops("st wait0", 32'hDEAD, 32'h11, 32'h100);
    bus.in_valid = 1'b1;
    bus.action_in = act2;
    @(negedge clk);
    chk_ops("st wait1", 32'hDEAD, 32'h11, 32'h100);
    chk("st wait in_ready", 256'(bus.in_ready), 256'(0));
    bus.alu_result = 32'h55;
    bus.alu_result_valid = 1'b1;
    @(negedge clk);
    bus.alu_result_valid = 1'b0;
    exp_phv = phv_a;
    exp_phv[31:0] = 32'h55;
    for (int i = 0; i < 5; i++) begin
      chk("bp out_valid", 256'(bus.phv_out_valid), 256'(1));
      chk("bp phv_out", bus.phv_out, exp_phv);
      chk("bp in_ready", 256'(bus.in_ready), 256'(0));
      chk("bp timeout_err", 256'(bus.timeout_err), 256'(0));
      chk("bp alu_action", 256'(bus.alu_action), 256'(act));
      chk_ops("bp hold", 32'hDEAD, 32'h11, 32'h100);
      if (i == 4) bus.phv_out_ready = 1'b1;
      @(negedge clk);
    end
    chk("bp released", 256'(bus.phv_out_valid), 256'(0));
    chk("bp no early accept", 256'(bus.alu_action), 256'(act));
    chk("bp idle ready", 256'(bus.in_ready), 256'(1));
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("addi accepted", 256'(bus.alu_action_valid), 256'(1));
    chk("addi alu_action", 256'(bus.alu_action), 256'(act2));
    chk_ops("addi", 32'd7, 32'h7FFF, 32'h100);
    @(negedge clk);
    bus.alu_result = 32'hABC;
    bus.alu_result_valid = 1'b1;
    @(negedge clk);
    bus.alu_result_valid = 1'b0;
    exp_phv = phv_a;
    exp_phv[31:0] = 32'hABC;
    chk("addi out_valid", 256'(bus.phv_out_valid), 256'(1));
    chk("addi phv_out", bus.phv_out, exp_phv);
    @(negedge clk);

    // ---- LOAD timeout; a stray result strobe in IDLE is ignored
    act = {OP_LOAD, 3'd5, 3'd6, 15'h1F};
    bus.action_in = act;
    bus.in_valid = 1'b1;
    bus.alu_result = 32'hBAD;
    bus.alu_result_valid = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.alu_result_valid = 1'b0;
      if (i == 1) chk_ops("ld", 32'h0, 32'h1F, 32'h100);
      if (i == 9) chk("to valid early", 256'(bus.phv_out_valid), 256'(0));
    end
    chk("to out_valid", 256'(bus.phv_out_valid), 256'(1));
    chk("to phv_out", bus.phv_out, phv_a);
    chk("to timeout_err", 256'(bus.timeout_err), 256'(1));
    @(negedge clk);

    // ---- coincidence: result on the terminal-count cycle wins
    act = {OP_ADD, 3'd4, 3'd5, 15'd0};
    bus.action_in = act;
    bus.in_valid = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.alu_result_valid = 1'b0;
      if (i == 1) chk_ops("co", 32'h1234_5678, 32'h0BAD_F00D, 32'h100);
      if (i == 9) begin
        chk("co valid early", 256'(bus.phv_out_valid), 256'(0));
        bus.alu_result = 32'h00C0_FFEE;
        bus.alu_result_valid = 1'b1;
      end
    end
    exp_phv = phv_a;
    exp_phv[31:0] = 32'h00C0_FFEE;
    chk("co out_valid", 256'(bus.phv_out_valid), 256'(1));
    chk("co phv_out", bus.phv_out, exp_phv);
    chk("co timeout_err", 256'(bus.timeout_err), 256'(0));
    @(negedge clk);

    // ---- reset during WAIT drops the transaction
    act = {OP_SUB, 3'd1, 3'd2, 15'd0};
    bus.action_in = act;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mrst in_ready", 256'(bus.in_ready), 256'(0));
    chk("mrst alu_action", 256'(bus.alu_action), 256'(0));
    chk("mrst phv_out", bus.phv_out, 256'(0));
    chk_ops("mrst", 32'h0, 32'h0, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    seen_valid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.phv_out_valid) seen_valid = 1'b1;
    end
    chk("mrst no phv_out_valid", 256'(seen_valid), 256'(0));

    // ---- fresh passthrough transaction after reset
    act = {4'b0101, 3'd1, 3'd2, 15'h1234};
    bus.action_in = act;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("pt action_valid", 256'(bus.alu_action_valid), 256'(1));
    chk_ops("pt", 32'h0, 32'h0, 32'h100);
    bus.alu_result = 32'h0000_5A5A;
    bus.alu_result_valid = 1'b1;
    @(negedge clk);
    @(negedge clk);
    bus.alu_result_valid = 1'b0;
    exp_phv = phv_a;
    exp_phv[31:0] = 32'h0000_5A5A;
    chk("pt out_valid", 256'(bus.phv_out_valid), 256'(1));
    chk("pt phv_out", bus.phv_out, exp_phv);
    chk("pt timeout_err", 256'(bus.timeout_err), 256'(0));
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
